cache_fill_fsm: RTL

- Miss-handling controller directly downstream of the data/instruction cache interface.
- When the cache reports a miss, it fetches the whole block from the multi-cycle main memory: one word request per cycle.
- Each returned word is written into the cache data array, and the tag array is written when the last word lands.
- Stalls the cache interface (fsm_busy) for the whole fill.

---
 rtl/cache_pkg.sv | 14 +
 rtl/fill_counter.sv | 27 ++
 rtl/cache_fill_fsm.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and block-geometry constants for the cache miss-fill controller.
package cache_pkg;

   localparam int unsigned WORDS         = 8;
   localparam int unsigned BLOCK_BYTES   = 2 * WORDS;
   localparam int unsigned OFFSET_BITS   = $clog2(BLOCK_BYTES);
   localparam int unsigned WORD_SEL_BITS = $clog2(WORDS);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

endpackage : cache_pkg

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear; done is registered and goes high when cnt reaches MAX.
module fill_counter #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned MAX   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (en && !done) begin
         cnt  <= cnt + CNT_W'(1);
         done <= (cnt + CNT_W'(1)) == CNT_W'(MAX);
      end
   end

endmodule : fill_counter

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: fetches a whole block word by word and writes data/tag arrays.
// Build option CACHE_FILL_CWF_EN enables critical-word-first ordering (default: ascending from base).
module cache_fill_fsm #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned WORDS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic [DATA_W-1:0] memory_data,
   input  logic              memory_data_valid,
   output logic              fsm_busy,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [ADDR_W-1:0] data_wr_addr,
   output logic [DATA_W-1:0] data_wr_word,
   output logic              write_tag_array
);
   import cache_pkg::*;

   localparam int unsigned WSEL  = $clog2(WORDS);
   localparam int unsigned OFF   = WSEL + 1;
   localparam int unsigned CNT_W = WSEL + 1;
   localparam int unsigned TAG_W = ADDR_W - OFF;

   state_t            state_q, state_d;
   logic [TAG_W-1:0]  blk_q;
   logic [WSEL-1:0]   start_q, start_d;
   logic              start_miss;
   logic [CNT_W-1:0]  iss_cnt, rx_cnt;
   logic              iss_done, rx_done;
   logic [WSEL-1:0]   iss_ofs, rx_ofs;
   logic              unused_lsb;

   // Word offset the fill starts from; byte-lane bits of the miss address carry no information here.
`ifdef CACHE_FILL_CWF_EN
   assign start_d    = miss_address[OFF-1:1];
   assign unused_lsb = miss_address[0];
`else
   assign start_d    = '0;
   assign unused_lsb = ^miss_address[OFF-1:0];
`endif

   fill_counter #(.CNT_W(CNT_W), .MAX(WORDS)) u_iss_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_miss),
      .en   (state_q == FILL),
      .cnt  (iss_cnt),
      .done (iss_done)
   );

   fill_counter #(.CNT_W(CNT_W), .MAX(WORDS)) u_rx_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (start_miss),
      .en   (write_data_array),
      .cnt  (rx_cnt),
      .done (rx_done)
   );

   // Offsets wrap modulo WORDS by truncation, so addresses stay inside the block.
   assign iss_ofs = WSEL'(iss_cnt + CNT_W'(start_q));
   assign rx_ofs  = WSEL'(rx_cnt + CNT_W'(start_q));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         blk_q   <= '0;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         if (start_miss) begin
            blk_q   <= miss_address[ADDR_W-1:OFF];
            start_q <= start_d;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      start_miss       = 1'b0;
      fsm_busy         = 1'b0;
      mem_ren          = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      data_wr_addr     = '0;
      data_wr_word     = '0;
      write_tag_array  = 1'b0;
      case (state_q)
         IDLE: begin
            // Stall starts in the miss cycle itself.
            fsm_busy = rst & miss_detected;
            if (miss_detected) begin
               start_miss = 1'b1;
               state_d    = FILL;
            end
         end
         FILL: begin
            fsm_busy = 1'b1;
            if (!iss_done) begin
               mem_ren        = 1'b1;
               memory_address = {blk_q, iss_ofs, 1'b0};
            end
            if (memory_data_valid && !rx_done) begin
               write_data_array = 1'b1;
               data_wr_addr     = {blk_q, rx_ofs, 1'b0};
               data_wr_word     = memory_data;
               if (rx_cnt == CNT_W'(WORDS - 1)) begin
                  write_tag_array = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule : cache_fill_fsm
